// File: rtl/ysyx_23060240_trap_ctrl.sv
// ============================================================================
// Module   : ysyx_23060240_trap_ctrl
// Brief    : M-mode CSR port sequencer for Zicsr, ecall trap entry and mret.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060240_trap_ctrl #(
    parameter logic [31:0] MCAUSE_ECALL = 32'hb,
    parameter logic [11:0] ADDR_MSTATUS = 12'h300,
    parameter logic [11:0] ADDR_MTVEC   = 12'h305,
    parameter logic [11:0] ADDR_MEPC    = 12'h341,
    parameter logic [11:0] ADDR_MCAUSE  = 12'h342
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] pc,
    input  logic        is_ecall,
    input  logic        is_mret,
    input  logic        is_csr,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_src,
    output logic [31:0] csr_rd_data,
    output logic        rd_we,
    output logic [11:0] csr_r_addr,
    input  logic [31:0] csr_r_data,
    output logic        csr_w_en,
    output logic [11:0] csr_w_addr,
    output logic [31:0] csr_w_data,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    localparam logic [1:0] C_OP_RW = 2'b01;
    localparam logic [1:0] C_OP_RS = 2'b10;
    localparam logic [1:0] C_OP_RC = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_T_CAUSE  = 3'd1,
        S_T_STATUS = 3'd2,
        S_T_JUMP   = 3'd3,
        S_M_JUMP   = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    logic        w_accept;
    logic [31:0] w_status_trap;
    logic [31:0] w_status_mret;
    logic [31:0] w_csr_new;

    assign w_accept = inst_valid & (state_q == S_IDLE);

    // Only MIE (3), MPIE (7) and MPP (12:11) move; every other bit passes through.
    always_comb begin
        w_status_trap        = csr_r_data;
        w_status_trap[7]     = csr_r_data[3];
        w_status_trap[3]     = 1'b0;
        w_status_trap[12:11] = 2'b11;

        w_status_mret        = csr_r_data;
        w_status_mret[3]     = csr_r_data[7];
        w_status_mret[7]     = 1'b1;
        w_status_mret[12:11] = 2'b11;
    end

    always_comb begin
        w_csr_new = 32'h0;
        case (csr_op)
            C_OP_RW: w_csr_new = csr_src;
            C_OP_RS: w_csr_new = csr_r_data | csr_src;
            C_OP_RC: w_csr_new = csr_r_data & ~csr_src;
            default: w_csr_new = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        inst_ready     = 1'b0;
        csr_rd_data    = 32'h0;
        rd_we          = 1'b0;
        csr_r_addr     = 12'h0;
        csr_w_en       = 1'b0;
        csr_w_addr     = 12'h0;
        csr_w_data     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        case (state_q)
            S_IDLE: begin
                inst_ready = 1'b1;
                if (w_accept) begin
                    if (is_ecall) begin
                        csr_w_en   = 1'b1;
                        csr_w_addr = ADDR_MEPC;
                        csr_w_data = {pc[31:2], 2'b00};
                        state_d    = S_T_CAUSE;
                    end else if (is_mret) begin
                        csr_r_addr = ADDR_MSTATUS;
                        csr_w_en   = 1'b1;
                        csr_w_addr = ADDR_MSTATUS;
                        csr_w_data = w_status_mret;
                        state_d    = S_M_JUMP;
                    end else if (is_csr && (csr_op != 2'b00)) begin
                        csr_r_addr  = csr_addr;
                        csr_rd_data = csr_r_data;
                        rd_we       = 1'b1;
                        // Set/clear with a zero mask must not touch the CSR.
                        if ((csr_op == C_OP_RW) || (csr_src != 32'h0)) begin
                            csr_w_en   = 1'b1;
                            csr_w_addr = csr_addr;
                            csr_w_data = w_csr_new;
                        end
                    end
                end
            end
            S_T_CAUSE: begin
                csr_w_en   = 1'b1;
                csr_w_addr = ADDR_MCAUSE;
                csr_w_data = MCAUSE_ECALL;
                state_d    = S_T_STATUS;
            end
            S_T_STATUS: begin
                csr_r_addr = ADDR_MSTATUS;
                csr_w_en   = 1'b1;
                csr_w_addr = ADDR_MSTATUS;
                csr_w_data = w_status_trap;
                state_d    = S_T_JUMP;
            end
            S_T_JUMP: begin
                csr_r_addr     = ADDR_MTVEC;
                redirect_valid = 1'b1;
                redirect_pc    = {csr_r_data[31:2], 2'b00};
                state_d        = S_IDLE;
            end
            S_M_JUMP: begin
                csr_r_addr     = ADDR_MEPC;
                redirect_valid = 1'b1;
                redirect_pc    = {csr_r_data[31:2], 2'b00};
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060240_trap_ctrl.sv
// ============================================================================
// Module   : tb_ysyx_23060240_trap_ctrl
// Brief    : Directed self-checking bench with a behavioural CSR file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060240_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] pc;
    logic        is_ecall;
    logic        is_mret;
    logic        is_csr;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_src;
    logic [31:0] csr_rd_data;
    logic        rd_we;
    logic [11:0] csr_r_addr;
    logic [31:0] csr_r_data;
    logic        csr_w_en;
    logic [11:0] csr_w_addr;
    logic [31:0] csr_w_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] csr_mem [0:4095];
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = 12'h0;
    logic [31:0] pre_data = 32'h0;

    always #5 clk = ~clk;

    assign csr_r_data = csr_mem[csr_r_addr];

    always @(posedge clk) begin
        if (pre_we) begin
            csr_mem[pre_addr] <= pre_data;
        end else if (csr_w_en) begin
            csr_mem[csr_w_addr] <= csr_w_data;
        end
    end

    ysyx_23060240_trap_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .pc             (pc),
        .is_ecall       (is_ecall),
        .is_mret        (is_mret),
        .is_csr         (is_csr),
        .csr_op         (csr_op),
        .csr_addr       (csr_addr),
        .csr_src        (csr_src),
        .csr_rd_data    (csr_rd_data),
        .rd_we          (rd_we),
        .csr_r_addr     (csr_r_addr),
        .csr_r_data     (csr_r_data),
        .csr_w_en       (csr_w_en),
        .csr_w_addr     (csr_w_addr),
        .csr_w_data     (csr_w_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    // Inputs change 1 after a rising edge; outputs are sampled 1 later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_valid = 1'b0; pc = 32'h0; is_ecall = 1'b0; is_mret = 1'b0;
        is_csr = 1'b0; csr_op = 2'b00; csr_addr = 12'h0; csr_src = 32'h0;
    endtask

    task automatic preset(input logic [11:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        next_cycle();
        pre_we = 1'b0;
    endtask

    task automatic drive_csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] s);
        idle_inputs();
        inst_valid = 1'b1; is_csr = 1'b1; csr_op = op; csr_addr = a; csr_src = s;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle(); next_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, inst_ready} !== 2'b01) begin
            errors++; $display("FAIL reset_state busy/ready got %b need 01", {busy, inst_ready});
        end
        checks++;
        if ({rd_we, csr_w_en, redirect_valid, csr_r_addr, csr_w_addr, csr_w_data, redirect_pc, csr_rd_data} !== 123'h0) begin
            errors++; $display("FAIL reset_outputs got %h need 0",
                {rd_we, csr_w_en, redirect_valid, csr_r_addr, csr_w_addr, csr_w_data, redirect_pc, csr_rd_data});
        end
    endtask

    task automatic test_zicsr();
        preset(12'h305, 32'h1234_5678);
        drive_csr(2'b01, 12'h305, 32'h8000_0100);
        checks++;
        if ({inst_ready, rd_we, csr_rd_data, csr_w_en, csr_w_addr, csr_w_data} !== {1'b1, 1'b1, 32'h1234_5678, 1'b1, 12'h305, 32'h8000_0100}) begin
            errors++; $display("FAIL csrrw got rd_we=%b old=%h w_en=%b wa=%h wd=%h need 1 12345678 1 305 80000100",
                rd_we, csr_rd_data, csr_w_en, csr_w_addr, csr_w_data);
        end
        next_cycle();
        drive_csr(2'b10, 12'h305, 32'h0);
        checks++;
        if ({rd_we, csr_rd_data, csr_w_en} !== {1'b1, 32'h8000_0100, 1'b0}) begin
            errors++; $display("FAIL csrrs_zero got rd_we=%b old=%h w_en=%b need 1 80000100 0", rd_we, csr_rd_data, csr_w_en);
        end
        next_cycle();
        drive_csr(2'b00, 12'h305, 32'hffff_ffff);
        checks++;
        if ({inst_ready, rd_we, csr_w_en, busy} !== 4'b1000) begin
            errors++; $display("FAIL csr_op00 got ready/rd_we/w_en/busy=%b need 1000", {inst_ready, rd_we, csr_w_en, busy});
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_ecall();
        preset(12'h305, 32'h8000_0103);
        preset(12'h300, 32'h0000_1808);
        idle_inputs();
        inst_valid = 1'b1; is_ecall = 1'b1; pc = 32'h8000_0046;
        #1;
        checks++;
        if ({inst_ready, rd_we, csr_w_en, csr_w_addr, csr_w_data} !== {1'b1, 1'b0, 1'b1, 12'h341, 32'h8000_0044}) begin
            errors++; $display("FAIL ecall_c0 got w_en=%b wa=%h wd=%h need 1 341 80000044", csr_w_en, csr_w_addr, csr_w_data);
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if ({inst_ready, busy, csr_w_en, csr_w_addr, csr_w_data} !== {1'b0, 1'b1, 1'b1, 12'h342, 32'hb}) begin
            errors++; $display("FAIL ecall_c1 got ready=%b w_en=%b wa=%h wd=%h need 0 1 342 b", inst_ready, csr_w_en, csr_w_addr, csr_w_data);
        end
        next_cycle();
        checks++;
        if ({inst_ready, csr_w_en, csr_w_addr, csr_w_data, redirect_valid} !== {1'b0, 1'b1, 12'h300, 32'h1880, 1'b0}) begin
            errors++; $display("FAIL ecall_c2 got w_en=%b wa=%h wd=%h rv=%b need 1 300 1880 0", csr_w_en, csr_w_addr, csr_w_data, redirect_valid);
        end
        next_cycle();
        checks++;
        if ({inst_ready, csr_w_en, redirect_valid, redirect_pc} !== {1'b0, 1'b0, 1'b1, 32'h8000_0100}) begin
            errors++; $display("FAIL ecall_c3 got ready=%b w_en=%b rv=%b rpc=%h need 0 0 1 80000100", inst_ready, csr_w_en, redirect_valid, redirect_pc);
        end
        next_cycle();
        checks++;
        if ({inst_ready, busy, redirect_valid} !== 3'b100) begin
            errors++; $display("FAIL ecall_c4 got ready/busy/rv=%b need 100", {inst_ready, busy, redirect_valid});
        end
        checks++;
        if ({csr_mem[12'h341], csr_mem[12'h342], csr_mem[12'h300]} !== {32'h8000_0044, 32'hb, 32'h1880}) begin
            errors++; $display("FAIL ecall_csrs got mepc=%h mcause=%h mstatus=%h need 80000044 b 1880",
                csr_mem[12'h341], csr_mem[12'h342], csr_mem[12'h300]);
        end
    endtask

    task automatic test_mret();
        idle_inputs();
        inst_valid = 1'b1; is_mret = 1'b1;
        #1;
        checks++;
        if ({csr_w_en, csr_w_addr, csr_w_data, redirect_valid} !== {1'b1, 12'h300, 32'h1888, 1'b0}) begin
            errors++; $display("FAIL mret_c0 got w_en=%b wa=%h wd=%h rv=%b need 1 300 1888 0", csr_w_en, csr_w_addr, csr_w_data, redirect_valid);
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if ({inst_ready, csr_w_en, redirect_valid, redirect_pc} !== {1'b0, 1'b0, 1'b1, 32'h8000_0044}) begin
            errors++; $display("FAIL mret_c1 got ready=%b w_en=%b rv=%b rpc=%h need 0 0 1 80000044", inst_ready, csr_w_en, redirect_valid, redirect_pc);
        end
        next_cycle();
        checks++;
        if ({busy, inst_ready, csr_mem[12'h300]} !== {2'b01, 32'h1888}) begin
            errors++; $display("FAIL mret_done got busy=%b ready=%b mstatus=%h need 0 1 1888", busy, inst_ready, csr_mem[12'h300]);
        end
    endtask

    task automatic test_back_to_back();
        drive_csr(2'b11, 12'h300, 32'h8);
        checks++;
        if ({rd_we, csr_rd_data, csr_w_en, csr_w_data} !== {1'b1, 32'h1888, 1'b1, 32'h1880}) begin
            errors++; $display("FAIL b2b_csrrc1 got old=%h w_en=%b wd=%h need 1888 1 1880", csr_rd_data, csr_w_en, csr_w_data);
        end
        next_cycle();
        drive_csr(2'b11, 12'h300, 32'h8);
        checks++;
        if ({inst_ready, rd_we, csr_rd_data, csr_w_en, csr_w_data} !== {1'b1, 1'b1, 32'h1880, 1'b1, 32'h1880}) begin
            errors++; $display("FAIL b2b_csrrc2 got old=%h w_en=%b wd=%h need 1880 1 1880", csr_rd_data, csr_w_en, csr_w_data);
        end
        next_cycle();
        idle_inputs();
        inst_valid = 1'b1; is_mret = 1'b1;
        #1;
        next_cycle();
        // ecall offered while M_JUMP is in progress must be held off.
        idle_inputs();
        inst_valid = 1'b1; is_ecall = 1'b1; pc = 32'h8000_0080;
        #1;
        checks++;
        if ({inst_ready, csr_w_en, redirect_valid, redirect_pc} !== {1'b0, 1'b0, 1'b1, 32'h8000_0044}) begin
            errors++; $display("FAIL b2b_busy got ready=%b w_en=%b rv=%b rpc=%h need 0 0 1 80000044", inst_ready, csr_w_en, redirect_valid, redirect_pc);
        end
        next_cycle();
        checks++;
        if ({inst_ready, csr_w_en, csr_w_addr, csr_w_data} !== {1'b1, 1'b1, 12'h341, 32'h8000_0080}) begin
            errors++; $display("FAIL b2b_ecall_accept got ready=%b w_en=%b wa=%h wd=%h need 1 1 341 80000080", inst_ready, csr_w_en, csr_w_addr, csr_w_data);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
        checks++;
        if ({csr_w_addr, csr_w_data} !== {12'h300, 32'h1880}) begin
            errors++; $display("FAIL b2b_trap_status got wa=%h wd=%h need 300 1880", csr_w_addr, csr_w_data);
        end
        next_cycle();
        checks++;
        if ({redirect_valid, redirect_pc} !== {1'b1, 32'h8000_0100}) begin
            errors++; $display("FAIL b2b_redirect got rv=%b rpc=%h need 1 80000100", redirect_valid, redirect_pc);
        end
        next_cycle();
    endtask

    task automatic test_rst_mid();
        logic seen_redirect;
        seen_redirect = 1'b0;
        idle_inputs();
        inst_valid = 1'b1; is_ecall = 1'b1; pc = 32'h8000_0200;
        #1;
        next_cycle();
        idle_inputs();
        next_cycle();
        rst = 1'b1;
        #1;
        seen_redirect = seen_redirect | redirect_valid;
        next_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, inst_ready} !== 2'b01) begin
            errors++; $display("FAIL rst_mid_state got busy/ready=%b need 01", {busy, inst_ready});
        end
        for (int i = 0; i < 4; i++) begin
            seen_redirect = seen_redirect | redirect_valid;
            next_cycle();
        end
        checks++;
        if (seen_redirect !== 1'b0) begin
            errors++; $display("FAIL rst_mid_redirect got %b need 0", seen_redirect);
        end
        checks++;
        if ({csr_mem[12'h341], csr_mem[12'h342]} !== {32'h8000_0200, 32'hb}) begin
            errors++; $display("FAIL rst_mid_csrs got mepc=%h mcause=%h need 80000200 b", csr_mem[12'h341], csr_mem[12'h342]);
        end
    endtask

    task automatic test_priority();
        preset(12'h305, 32'h8000_0103);
        preset(12'h300, 32'h0000_0008);
        drive_csr(2'b01, 12'h305, 32'hdead_beef);
        is_ecall = 1'b1; pc = 32'h8000_0300;
        #1;
        checks++;
        if ({rd_we, csr_w_addr, csr_w_data} !== {1'b0, 12'h341, 32'h8000_0300}) begin
            errors++; $display("FAIL prio_c0 got rd_we=%b wa=%h wd=%h need 0 341 80000300", rd_we, csr_w_addr, csr_w_data);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
        checks++;
        if ({csr_w_addr, csr_w_data} !== {12'h300, 32'h1880}) begin
            errors++; $display("FAIL prio_status got wa=%h wd=%h need 300 1880", csr_w_addr, csr_w_data);
        end
        next_cycle();
        checks++;
        if ({redirect_valid, redirect_pc, csr_mem[12'h305]} !== {1'b1, 32'h8000_0100, 32'h8000_0103}) begin
            errors++; $display("FAIL prio_jump got rv=%b rpc=%h mtvec=%h need 1 80000100 80000103", redirect_valid, redirect_pc, csr_mem[12'h305]);
        end
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zicsr();
        test_ecall();
        test_mret();
        test_back_to_back();
        test_rst_mid();
        test_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ysyx_23060240_trap_ctrl.md
# ysyx_23060240_trap_ctrl

Sequencer that owns the single read port and single write port of the machine-mode CSR file. It accepts one retiring instruction at a time from EXU and handles three cases: Zicsr reads and writes, `ecall` trap entry, and `mret` trap return. It breaks trap entry and trap return into per-cycle CSR writes and issues the PC redirect to IFU. While a sequence runs, it holds the pipeline off through `inst_ready`.

## Interface
Parameters:
- `MCAUSE_ECALL`, default 32'hb: value written to mcause on `ecall`.
- `ADDR_MSTATUS`, `ADDR_MTVEC`, `ADDR_MEPC`, `ADDR_MCAUSE`, defaults 12'h300, 12'h305, 12'h341, 12'h342.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `inst_valid` in 1: EXU has a retiring instruction. Held until accepted.
- `inst_ready` out 1: controller can accept. Accept = `inst_valid & inst_ready`.
- `pc` in 32: PC of the offered instruction.
- `is_ecall`, `is_mret`, `is_csr` in 1: instruction class flags.
- `csr_op` in 2: 01 CSRRW, 10 CSRRS, 11 CSRRC, 00 reserved (treated as no-op).
- `csr_addr` in 12: CSR address of a Zicsr instruction.
- `csr_src` in 32: rs1 value or zero-extended immediate.
- `csr_rd_data` out 32: old CSR value for rd writeback.
- `rd_we` out 1: one-cycle pulse; `csr_rd_data` is valid in that cycle.
- `csr_r_addr` out 12: CSR file read address.
- `csr_r_data` in 32: combinational CSR file read data.
- `csr_w_en` out 1, `csr_w_addr` out 12, `csr_w_data` out 32: CSR file write port. The write commits on the next rising edge.
- `redirect_valid` out 1, `redirect_pc` out 32: one-cycle next-PC override to IFU.
- `busy` out 1: high when state is not IDLE.

## Operation
FSM states: IDLE, T_CAUSE, T_STATUS, T_JUMP, M_JUMP. Only the state register is sequential. All outputs are combinational from the state and inputs.

IDLE:
- `inst_ready`=1. `inst_ready` is 0 in every other state.
- On accept, flag priority is `is_ecall` > `is_mret` > `is_csr`.
- `is_ecall`: write mepc = `pc` with bits [1:0] forced to 0. Go to T_CAUSE.
- `is_mret`: read mstatus and write mstatus' (mret rule below). Go to M_JUMP.
- `is_csr`: read `csr_addr` and drive `csr_rd_data` = `csr_r_data` with `rd_we`=1.
  - Write value: RW → `csr_src`; RS → old | src; RC → old & ~src.
  - `csr_w_en`=1 for RW always. For RS/RC only when `csr_src`≠0.
  - Stay in IDLE; a new instruction can be accepted every cycle.
- No flag set, or `csr_op`=00: accepted with no action. Stay in IDLE.

Trap entry:
- T_CAUSE: write mcause = `MCAUSE_ECALL`. Go to T_STATUS.
- T_STATUS: read mstatus and write mstatus' (trap rule below). Go to T_JUMP.
- T_JUMP: read mtvec. `redirect_valid`=1, `redirect_pc` = {mtvec[31:2],2'b00} (direct mode only). Go to IDLE.

Trap return:
- M_JUMP: read mepc. `redirect_valid`=1, `redirect_pc` = {mepc[31:2],2'b00}. Go to IDLE.

mstatus rules (MIE = bit 3, MPIE = bit 7, MPP = bits 12:11; all other bits pass through unchanged):
- Trap: MPIE ← old MIE, MIE ← 0, MPP ← 2'b11.
- mret: MIE ← old MPIE, MPIE ← 1, MPP ← 2'b11 (M-mode only).

Defaults:
- `csr_w_en`, `rd_we`, `redirect_valid` are 0 outside the cases above.
- `csr_r_addr`, `csr_w_addr`, `csr_w_data`, `redirect_pc`, `csr_rd_data` are 0 when not in use.

The controller does not filter addresses. Unknown `csr_addr` values are forwarded to the CSR file unchanged.

## Timing
- Reset: state = IDLE, `busy`=0, `inst_ready`=1. With `inst_valid`=0, every other output is 0.
- Zicsr: 1 cycle. `rd_we` is asserted in the accept cycle, and the new value is visible on the following cycle.
- ecall: accept cycle plus 3 cycles. `redirect_valid` is asserted 3 cycles after accept. The next accept is possible on cycle 4.
- mret: accept cycle plus 1 cycle. `redirect_valid` is asserted 1 cycle after accept.
- Each sequencing state lasts exactly 1 cycle. The CSR file never stalls.
- `inst_valid` while busy: ignored. EXU must keep holding the instruction.
- `rst` mid-sequence: state returns to IDLE on that edge. No redirect is issued, and CSR writes already committed remain.
- A T_JUMP or M_JUMP read sees writes committed on earlier edges only. The sequence is ordered so that mtvec and mepc are never written inside a sequence.

## Test plan
- CSRRW 0x305 with src 0x8000_0100: `rd_we`=1 with the old mtvec, `csr_w_en`=1; the next cycle reads back 0x8000_0100. Then CSRRS 0x305 with src 0 gives `csr_w_en`=0.
- ecall at pc 0x8000_0044, mtvec 0x8000_0103, mstatus 0x1808:
  - cycle 0 writes mepc 0x8000_0044;
  - cycle 1 writes mcause 0xb;
  - cycle 2 writes mstatus 0x1880;
  - cycle 3 drives `redirect_pc` 0x8000_0100 with `redirect_valid`=1;
  - `inst_ready`=0 for cycles 1–3.
- mret with mepc 0x8000_0044, mstatus 0x1880: cycle 0 writes mstatus 0x1888; cycle 1 drives redirect to 0x8000_0044.
- Back-to-back: CSRRC 0x300 with src 0x8 on consecutive accepted cycles, then ecall presented while busy: no duplicate CSR writes, and the ecall sequence starts only after the prior sequence returns to IDLE.
- `rst` asserted in T_STATUS: the next cycle is IDLE, `redirect_valid` never pulses, and mepc and mcause hold the values written before reset.
- `is_ecall` and `is_csr` both set: only the trap sequence runs, with `rd_we`=0.
